fetch_pc_unit: RTL and testbench

Program-counter and instruction-fetch sequencer; consumes the `select`/`addressout` redirect pair produced by the branch/jump controller. Holds the architectural PC and steps it by 4 after every delivered instruction. Runs a request/acknowledge fetch to instruction memory and presents each fetched word to decode under a valid/ready handshake. On a redirect it discards wrong-path fetches and restarts at the target.

---
 rtl/fetch_pc_unit.sv | 129 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// PC / instruction-fetch sequencer: req/ack fetch, valid/ready delivery, redirect with wrong-path squash.
// Optional misaligned-redirect trap is built when FETCH_ALIGN_CHECK_EN is defined.
module fetch_pc_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_data,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] instr_pc_plus4,
    input  logic              instr_ready,
    output logic              align_fault
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, target, target_n, redir_addr;
    logic              squash, squash_n, fault_pend, fault_pend_n;
    logic              armed, latch, redir_bad;

`ifdef FETCH_ALIGN_CHECK_EN
    logic set_fault;
    assign redir_addr = redirect_addr;
    assign redir_bad  = |redirect_addr[1:0];
    assign set_fault  = redirect_valid & redir_bad & (state != FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         align_fault <= 1'b0;
        else if (set_fault) align_fault <= 1'b1;
    end
`else
    logic unused_lsb;
    assign unused_lsb  = ^redirect_addr[1:0];
    assign redir_addr  = {redirect_addr[ADDR_W-1:2], 2'b00};
    assign redir_bad   = 1'b0;
    assign align_fault = 1'b0;
`endif

    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == HOLD);

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        target_n     = target;
        squash_n     = squash;
        fault_pend_n = fault_pend;
        latch        = 1'b0;
        case (state)
            IDLE: begin
                // armed keeps IDLE for one full cycle after reset release
                if (redirect_valid) begin
                    pc_n    = redir_addr;
                    state_n = redir_bad ? FAULT : FETCH;
                end else if (armed) begin
                    state_n = FETCH;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    squash_n = 1'b0;
                    if (redirect_valid) begin
                        pc_n = redir_addr;
                        if (redir_bad || fault_pend) state_n = FAULT;
                    end else if (squash) begin
                        pc_n = target;
                        if (fault_pend) state_n = FAULT;
                    end else begin
                        latch   = 1'b1;
                        state_n = HOLD;
                    end
                end else if (redirect_valid) begin
                    // request is in flight: keep imem_addr, drop its data later
                    squash_n = 1'b1;
                    target_n = redir_addr;
                    if (redir_bad) fault_pend_n = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_n    = redir_addr;
                    state_n = redir_bad ? FAULT : FETCH;
                end else if (instr_ready) begin
                    pc_n    = pc + ADDR_W'(4);
                    state_n = FETCH;
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            FAULT: state_n = FAULT;
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            armed          <= 1'b0;
            pc             <= RESET_PC;
            target         <= '0;
            squash         <= 1'b0;
            fault_pend     <= 1'b0;
            instr          <= '0;
            instr_pc       <= '0;
            instr_pc_plus4 <= '0;
        end else begin
            state      <= state_n;
            armed      <= 1'b1;
            pc         <= pc_n;
            target     <= target_n;
            squash     <= squash_n;
            fault_pend <= fault_pend_n;
            if (latch) begin
                instr          <= imem_data;
                instr_pc       <= pc;
                instr_pc_plus4 <= pc + ADDR_W'(4);
            end
        end
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: reset, sequential fetch, backpressure, redirects, wrap, misalignment.
module tb_fetch_pc_unit;
    logic        clk, rst_n;
    logic        redirect_valid, imem_ack, instr_ready;
    logic [31:0] redirect_addr, imem_data;
    logic        imem_req, instr_valid, align_fault;
    logic [31:0] imem_addr, instr, instr_pc, instr_pc_plus4;

    int n_cmp = 0;
    int n_err = 0;

    fetch_pc_unit #(.ADDR_W(32), .RESET_PC(32'h100)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_pc_plus4(instr_pc_plus4), .instr_ready(instr_ready),
        .align_fault(align_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   {31'd0, imem_req},    32'd0);
        chk({tag, "_addr"},  imem_addr,            32'h100);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_instr"}, instr,                32'd0);
        chk({tag, "_pc"},    instr_pc,             32'd0);
        chk({tag, "_pc4"},   instr_pc_plus4,       32'd0);
        chk({tag, "_fault"}, {31'd0, align_fault}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
        imem_ack = 1'b0; imem_data = '0; instr_ready = 1'b0;
        tick(); tick();
        chk_reset("rst");

        rst_n = 1'b1;
        tick();
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h100);

        // sequential fetch
        imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        chk("seq_valid", {31'd0, instr_valid}, 32'd1);
        chk("seq_instr", instr, 32'hDEAD_BEEF);
        chk("seq_pc", instr_pc, 32'h100);
        chk("seq_pc4", instr_pc_plus4, 32'h104);
        chk("seq_req_off", {31'd0, imem_req}, 32'd0);

        // backpressure
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", {31'd0, instr_valid}, 32'd1);
            chk("bp_instr", instr, 32'hDEAD_BEEF);
            chk("bp_pc", instr_pc, 32'h100);
            chk("bp_req", {31'd0, imem_req}, 32'd0);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("next_req", {31'd0, imem_req}, 32'd1);
        chk("next_addr", imem_addr, 32'h104);
        chk("next_valid", {31'd0, instr_valid}, 32'd0);

        // redirect while fetch outstanding, ack two cycles later
        redirect_valid = 1'b1; redirect_addr = 32'h300;
        tick();
        redirect_valid = 1'b0;
        chk("sq_addr0", imem_addr, 32'h104);
        tick();
        chk("sq_addr1", imem_addr, 32'h104);
        chk("sq_req1", {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b1; imem_data = 32'h1111_1111;
        tick();
        imem_ack = 1'b0;
        chk("sq_drop", {31'd0, instr_valid}, 32'd0);
        chk("sq_req", {31'd0, imem_req}, 32'd1);
        chk("sq_target", imem_addr, 32'h300);

        imem_ack = 1'b1; imem_data = 32'hCAFE_F00D;
        tick();
        imem_ack = 1'b0;
        chk("tgt_instr", instr, 32'hCAFE_F00D);
        chk("tgt_pc", instr_pc, 32'h300);
        chk("tgt_pc4", instr_pc_plus4, 32'h304);

        // redirect from HOLD without ready
        redirect_valid = 1'b1; redirect_addr = 32'h200;
        tick();
        redirect_valid = 1'b0;
        chk("hold_rd_valid", {31'd0, instr_valid}, 32'd0);
        chk("hold_rd_req", {31'd0, imem_req}, 32'd1);
        chk("hold_rd_addr", imem_addr, 32'h200);

        // redirect coincident with ack, to the top of the address space
        imem_ack = 1'b1; imem_data = 32'h2222_2222;
        redirect_valid = 1'b1; redirect_addr = 32'hFFFF_FFFC;
        tick();
        imem_ack = 1'b0; redirect_valid = 1'b0;
        chk("coin_valid", {31'd0, instr_valid}, 32'd0);
        chk("coin_req", {31'd0, imem_req}, 32'd1);
        chk("coin_addr", imem_addr, 32'hFFFF_FFFC);

        imem_ack = 1'b1; imem_data = 32'h1234_5678;
        tick();
        imem_ack = 1'b0;
        chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", instr_pc_plus4, 32'h0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_req", {31'd0, imem_req}, 32'd1);

        imem_ack = 1'b1; imem_data = 32'hAAAA_5555;
        tick();
        imem_ack = 1'b0;
        chk("zero_pc", instr_pc, 32'h0);

        // misaligned redirect from HOLD
        redirect_valid = 1'b1; redirect_addr = 32'h202;
        tick();
        redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_fault", {31'd0, align_fault}, 32'd1);
        chk("mis_req", {31'd0, imem_req}, 32'd0);
        chk("mis_valid", {31'd0, instr_valid}, 32'd0);
        imem_ack = 1'b1; instr_ready = 1'b1;
        tick(); tick();
        imem_ack = 1'b0; instr_ready = 1'b0;
        chk("mis_fault_sticky", {31'd0, align_fault}, 32'd1);
        chk("mis_req_stuck", {31'd0, imem_req}, 32'd0);
`else
        chk("mis_fault", {31'd0, align_fault}, 32'd0);
        chk("mis_req", {31'd0, imem_req}, 32'd1);
        chk("mis_addr", imem_addr, 32'h200);
`endif

        // reset mid-operation, late ack during IDLE
        rst_n = 1'b0;
        #1;
        chk_reset("mid_rst");
        tick();
        imem_ack = 1'b1; imem_data = 32'h5555_AAAA;
        rst_n = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("late_ack_req", {31'd0, imem_req}, 32'd0);
        chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
        chk("late_ack_instr", instr, 32'd0);
        tick();
        chk("restart_req", {31'd0, imem_req}, 32'd1);
        chk("restart_addr", imem_addr, 32'h100);
        chk("restart_valid", {31'd0, instr_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
